// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO buffer controller slice.
// Holds default sizing, the ceiling-log2 helper and the count-width helper.
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 16;
   localparam int unsigned DEF_AF_MARGIN  = 2;
   localparam int unsigned DEF_AE_MARGIN  = 2;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one synchronous read port.
// No reset on the array or the read register; contents survive a controller reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = clog2(DEF_FIFO_DEPTH)
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port, holds its value while re is low
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fifo_buffer_ctrl.sv
// Parametrised synchronous FIFO controller with occupancy count, programmable
// almost-full/almost-empty, sticky overflow/underflow and read-valid.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output;
// leave it undefined for standard registered-read mode.
module fifo_buffer_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned AF_MARGIN  = DEF_AF_MARGIN,
   parameter int unsigned AE_MARGIN  = DEF_AE_MARGIN
)(
   input  logic                        clk_1MHz,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        rd_en,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic                        rd_valid,
   input  logic                        clr_err,
   output logic [clog2(FIFO_DEPTH):0]  count,
   output logic                        empty,
   output logic                        full,
   output logic                        almost_empty,
   output logic                        almost_full,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int unsigned AW = clog2(FIFO_DEPTH);
   localparam int unsigned CW = cnt_width(FIFO_DEPTH);

   localparam logic [CW-1:0] DEPTH_LVL = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_LVL    = CW'(FIFO_DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] AE_LVL    = CW'(AE_MARGIN);

   // rst_n is an active-high synchronous reset on this block
   logic rst;
   assign rst = rst_n;

   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [AW:0]           wr_ptr_next;
   logic [AW:0]           rd_ptr_next;
   logic [CW-1:0]         count_next;
   logic                  wr_accept;
   logic                  rd_accept;
   logic                  ovf_set;
   logic                  unf_set;

   logic                  ram_we;
   logic                  ram_re;
   logic [AW-1:0]         ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Request acceptance and next-state pointers/occupancy from pre-edge flags
   always_comb begin
      wr_accept   = wr_en && !full;
      rd_accept   = rd_en && !empty;
      ovf_set     = wr_en && full;
      unf_set     = rd_en && empty;
      wr_ptr_next = wr_ptr + (AW+1)'(wr_accept);
      rd_ptr_next = rd_ptr + (AW+1)'(rd_accept);
      count_next  = count + CW'(wr_accept) - CW'(rd_accept);
   end

   // Pointers, occupancy and level flags, all taken from the next-state count
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         count        <= count_next;
         empty        <= (count_next == '0);
         full         <= (count_next == DEPTH_LVL);
         almost_empty <= (count_next <= AE_LVL);
         almost_full  <= (count_next >= AF_LVL);
      end
   end

   // Sticky error flags; a new rejection wins over a simultaneous clear
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (unf_set) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

   // Writes during reset are dropped so the array only changes on accepted writes
   assign ram_we = wr_accept && !rst;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk   (clk_1MHz),
      .we    (ram_we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (data_in),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

`ifdef FIFO_FWFT_EN

   logic                  byp_hit;
   logic                  byp_sel;
   logic [DATA_WIDTH-1:0] byp_data;

   // Keep the RAM read register pointed at the upcoming head every cycle
   assign ram_re    = 1'b1;
   assign ram_raddr = rd_ptr_next[AW-1:0];

   // The word being written becomes the head this edge, so the RAM read misses it
   assign byp_hit = wr_accept && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0]);

   // Head-valid flag and write-to-head bypass capture
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         rd_valid <= 1'b0;
         byp_sel  <= 1'b0;
         byp_data <= '0;
      end else begin
         rd_valid <= (count_next != '0);
         byp_sel  <= byp_hit;
         if (byp_hit) begin
            byp_data <= data_in;
         end
      end
   end

   // Head word whenever non-empty, zero otherwise
   assign data_out = !rd_valid ? '0 : (byp_sel ? byp_data : ram_rdata);

`else

   logic rd_seen;

   // RAM read register loads the head only on an accepted read
   assign ram_re    = rd_accept && !rst;
   assign ram_raddr = rd_ptr[AW-1:0];

   // One-cycle read-valid pulse and first-read tracking for the zero reset value
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_seen  <= 1'b0;
      end else begin
         rd_valid <= rd_accept;
         if (rd_accept) begin
            rd_seen <= 1'b1;
         end
      end
   end

   // Last popped word, held between reads; zero until the first read after reset
   assign data_out = rd_seen ? ram_rdata : '0;

`endif

endmodule

// File: tb/tb_fifo_buffer_ctrl.sv
// Self-checking bench for fifo_buffer_ctrl (DATA_WIDTH=8, FIFO_DEPTH=8, margins 2).
// Works for both the default build and the FIFO_FWFT_EN build.
`timescale 1ns/1ps
module tb_fifo_buffer_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 8;

   logic          clk_1MHz = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_en;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          clr_err;
   logic [3:0]    count;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];      // reference contents
   logic [DW-1:0] exp_q[$];   // scoreboard of words the DUT must present
   bit            m_ovf;
   bit            m_unf;
   bit            mon_en = 1'b0;

   fifo_buffer_ctrl #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .AF_MARGIN  (2),
      .AE_MARGIN  (2)
   ) dut (
      .clk_1MHz     (clk_1MHz),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .clr_err      (clr_err),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #500 clk_1MHz = ~clk_1MHz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Compare status outputs with the reference contents
   task automatic check_state(input string tag);
      int n;
      n = mq.size();
      chk({tag, ":count"},        32'(count),        32'(n));
      chk({tag, ":empty"},        32'(empty),        32'(n == 0));
      chk({tag, ":full"},         32'(full),         32'(n == 8));
      chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= 2));
      chk({tag, ":almost_full"},  32'(almost_full),  32'(n >= 6));
      chk({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
      chk({tag, ":underflow"},    32'(underflow),    32'(m_unf));
   endtask

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c,
                       input string tag);
      int n;
      bit wr_ok;
      bit rd_ok;
      bit exp_rv;
      n     = mq.size();
      wr_ok = w && (n < 8);
      rd_ok = r && (n > 0);
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      clr_err = c;
      if (rd_ok) exp_q.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(d);
      if (w && n == 8) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && n == 0) m_unf = 1'b1; else if (c) m_unf = 1'b0;
      @(posedge clk_1MHz);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
`ifdef FIFO_FWFT_EN
      exp_rv = (mq.size() > 0);
`else
      exp_rv = rd_ok;
`endif
      chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(exp_rv));
      check_state(tag);
   endtask

   task automatic do_reset(input int cycles, input string tag);
      rst_n   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      data_in = '0;
      repeat (cycles) @(posedge clk_1MHz);
      #1;
      rst_n = 1'b0;
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      chk({tag, ":data_out"}, 32'(data_out), 32'h0);
      chk({tag, ":rd_valid"}, 32'(rd_valid), 32'h0);
      check_state(tag);
   endtask

   // Scoreboard monitor: consumes expected words when the DUT presents output
   always @(negedge clk_1MHz) begin
      logic [DW-1:0] e;
      if (mon_en) begin
`ifdef FIFO_FWFT_EN
         if (rd_valid && rd_en) begin
`else
         if (rd_valid) begin
`endif
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected actual=0x%0h expected=none", data_out);
            end else begin
               e = exp_q.pop_front();
               chk("sb_data_out", 32'(data_out), 32'(e));
            end
         end
      end
   end

   initial begin
      rst_n   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      data_in = '0;
      do_reset(2, "reset");
      mon_en = 1'b1;

      // Fill 0x01..0x08 with explicit level milestones
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
         chk("fill_count",  32'(count),        32'(i));
         chk("fill_ae",     32'(almost_empty), 32'(i <= 2));
         chk("fill_af",     32'(almost_full),  32'(i >= 6));
         chk("fill_full",   32'(full),         32'(i == 8));
      end

      // Write while full is rejected
      step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
      chk("ovf_flag",  32'(overflow), 32'h1);
      chk("ovf_count", 32'(count),    32'h8);

      // Full with rd+wr: read wins, write rejected
      step(1'b1, 8'hBB, 1'b1, 1'b0, "full_rdwr");
      chk("full_rdwr_count", 32'(count), 32'h7);

      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      step(1'b0, 8'h00, 1'b0, 1'b0, "idle");
      chk("drain_empty", 32'(empty), 32'h1);

      step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");
      chk("clr_ovf_flag", 32'(overflow), 32'h0);

      // Underflow and sticky behaviour
      step(1'b0, 8'h00, 1'b1, 1'b0, "unf");
      chk("unf_flag",  32'(underflow), 32'h1);
      chk("unf_rdv",   32'(rd_valid),  32'h0);
      step(1'b0, 8'h00, 1'b0, 1'b0, "unf_idle");
      chk("unf_rdv2",  32'(rd_valid),  32'h0);
      chk("unf_hold",  32'(underflow), 32'h1);
      step(1'b0, 8'h00, 1'b1, 1'b1, "unf_setclr");
      chk("unf_set_beats_clr", 32'(underflow), 32'h1);
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr_unf");
      chk("clr_unf_flag", 32'(underflow), 32'h0);

      // Empty with rd+wr: write wins, read rejected
      step(1'b1, 8'h33, 1'b1, 1'b0, "empty_rdwr");
      chk("empty_rdwr_count", 32'(count),     32'h1);
      chk("empty_rdwr_unf",   32'(underflow), 32'h1);
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

      // Simultaneous traffic at count=4 across pointer wrap
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h34 + i), 1'b0, 1'b0, "to4");
      chk("sim_start_count", 32'(count), 32'h4);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "sim");
         chk("sim_count", 32'(count), 32'h4);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "sim_drain");
      step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

      // Output mode behaviour
`ifdef FIFO_FWFT_EN
      step(1'b1, 8'h5C, 1'b0, 1'b0, "mode_wr");
      chk("fwft_data", 32'(data_out), 32'h5C);
      chk("fwft_rdv",  32'(rd_valid), 32'h1);
      step(1'b0, 8'h00, 1'b0, 1'b0, "mode_idle");
      chk("fwft_hold", 32'(data_out), 32'h5C);
      step(1'b0, 8'h00, 1'b1, 1'b0, "mode_rd");
      chk("fwft_rdv_after_pop", 32'(rd_valid), 32'h0);
`else
      step(1'b1, 8'h5C, 1'b0, 1'b0, "mode_wr");
      chk("std_rdv_wr",  32'(rd_valid), 32'h0);
      step(1'b0, 8'h00, 1'b0, 1'b0, "mode_idle");
      chk("std_rdv_idle", 32'(rd_valid), 32'h0);
      step(1'b0, 8'h00, 1'b1, 1'b0, "mode_rd");
      chk("std_rdv_rd",  32'(rd_valid), 32'h1);
      chk("std_data_rd", 32'(data_out), 32'h5C);
      step(1'b0, 8'h00, 1'b0, 1'b0, "mode_idle2");
      chk("std_rdv_off", 32'(rd_valid), 32'h0);
      chk("std_data_hold", 32'(data_out), 32'h5C);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

      // Reset mid-operation discards contents
      step(1'b1, 8'h11, 1'b0, 1'b0, "pre_rst");
      step(1'b1, 8'h22, 1'b0, 1'b0, "pre_rst");
      step(1'b1, 8'h33, 1'b0, 1'b0, "pre_rst");
      do_reset(1, "mid_reset");
      step(1'b1, 8'h77, 1'b0, 1'b0, "post_rst");
      step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");
      step(1'b0, 8'h00, 1'b0, 1'b0, "idle");
      step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

      chk("sb_leftover", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
